// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Valid/ready input handshake; one-cycle out_valid pulse when bcd is updated.
module bcd_conv_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid
);

  localparam int unsigned SW = 4*DIGITS + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   nxt;
  logic [CW-1:0]   cnt;

  // Scratch is {bcd_acc, bin}; every digit is corrected before the shift.
  always_comb begin
    adj = sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr[WIDTH+4*i +: 4] >= 4'd5)
        adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
    end
    nxt = adj << 1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      bcd       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr       <= {{(4*DIGITS){1'b0}}, in_data};
            cnt      <= CW'(WIDTH);
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          sr  <= nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd       <= nxt[SW-1:WIDTH];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed, table-driven bench for bcd_conv_seq with hand-written sequences
// for reset, busy-ignore and mid-conversion reset.
module tb_bcd_conv_seq;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic [11:0] bcd;
  logic        out_valid;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [10];

  bcd_conv_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .bcd       (bcd),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [11:0] dec2bcd(input int unsigned v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Accept v on the next edge, then time the completion pulse.
  task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string name);
    int unsigned cyc;
    logic [11:0] prev;
    logic        held;
    @(negedge clk);
    in_data  = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~v;
    chk({name, "_ready_low"}, in_ready, 1'b0);
    prev = bcd;
    held = 1'b1;
    cyc  = 1;
    while (cyc <= 20) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
      if (bcd !== prev || busy !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
      cyc++;
    end
    chk({name, "_latency"}, cyc, 8);
    chk({name, "_bcd"}, bcd, exp);
    chk({name, "_held"}, held, 1'b1);
    @(posedge clk);
    #1;
    chk({name, "_pulse_end"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd55;

    vecs[0] = '{8'd0,   12'h000};
    vecs[1] = '{8'd255, 12'h255};
    vecs[2] = '{8'd100, 12'h100};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd57,  12'h057};
    vecs[5] = '{8'd9,   12'h009};
    vecs[6] = '{8'd10,  12'h010};
    vecs[7] = '{8'd199, 12'h199};
    vecs[8] = '{8'd128, 12'h128};
    vecs[9] = '{8'd250, 12'h250};

    // Reset held with in_valid high
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_bcd", bcd, 12'h000);
      chk("rst_outs", {out_valid, in_ready, busy}, 3'b010);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;

    for (int i = 0; i < 10; i++)
      convert(vecs[i].din, vecs[i].exp, "vec");

    // Counter sweep 0..99 then wrap to 0
    for (int i = 0; i <= 100; i++)
      convert(8'(i % 100), dec2bcd(i % 100), "sweep");

    // Busy ignore: 17 presented during 42's conversion, held until accepted
    @(negedge clk);
    in_data  = 8'd42;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    for (int i = 1; i <= 18; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        in_data  = 8'd17;
        in_valid = 1'b1;
      end
      if (i == 7) chk("busy_no_early", {out_valid, busy}, 2'b01);
      if (i == 8) chk("busy_first", {out_valid, bcd}, {1'b1, 12'h042});
      if (i == 9) chk("busy_gap", {out_valid, in_ready, busy}, 3'b010);
      if (i == 10) begin
        chk("busy_accept", {in_ready, busy}, 2'b01);
        in_valid = 1'b0;
      end
      if (i == 17) chk("busy_not_yet", {out_valid, bcd}, {1'b0, 12'h042});
      if (i == 18) chk("busy_second", {out_valid, bcd}, {1'b1, 12'h017});
    end
    @(posedge clk);
    #1;

    // Mid-conversion reset discards the partial result
    @(negedge clk);
    in_data  = 8'd200;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_bcd", bcd, 12'h000);
    chk("mid_rst_outs", {out_valid, in_ready, busy}, 3'b010);
    @(negedge clk);
    rst = 1'b1;
    begin
      logic pulsed;
      pulsed = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (out_valid || busy) pulsed = 1'b1;
      end
      chk("mid_rst_no_pulse", pulsed, 1'b0);
    end
    convert(8'd7, 12'h007, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
